// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1-to-N stream demultiplexer.
package demux_pkg;

   localparam int                      DEMUX_DROP_W   = 16;
   localparam logic [DEMUX_DROP_W-1:0] DEMUX_DROP_MAX = 16'hFFFF;

   // True when a select value addresses an existing channel.
   function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned nch);
      return (sel < nch);
   endfunction

endpackage

// File: rtl/chan_reg_slice.sv
// One-entry output register for a single demux channel; a load in the same
// cycle as a drain replaces the held word so the channel sustains 1 word/cycle.
module chan_reg_slice #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             drain_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             vld_o,
   output logic [WIDTH-1:0] data_o
);

   logic             vld_q;
   logic             vld_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Next-state: load wins over drain, otherwise hold.
   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (load_i) begin
         vld_d  = 1'b1;
         data_d = data_i;
      end else if (drain_i) begin
         vld_d  = 1'b0;
      end else begin
         vld_d  = vld_q;
      end
   end

   // Channel register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign vld_o  = vld_q;
   assign data_o = vld_q ? data_q : '0;

endmodule

// File: rtl/demux_1xn_reg.sv
// Registered 1-to-NCH valid/ready demultiplexer with zero-filled idle channels.
// Optional saturating out-of-range drop counter enabled by DEMUX_DROP_CNT_EN.
module demux_1xn_reg
   import demux_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NCH   = 8,
   parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [WIDTH-1:0]          y_in,
   input  logic [SELW-1:0]           sel_in,
   input  logic                      valid_in,
   output logic                      ready_out,
   output logic [NCH-1:0][WIDTH-1:0] data_out,
   output logic [NCH-1:0]            valid_out,
   input  logic [NCH-1:0]            ready_in
`ifdef DEMUX_DROP_CNT_EN
   ,
   output logic [DEMUX_DROP_W-1:0]   drop_cnt_out
`endif
);

   logic                      sel_ok_s;
   logic                      acc_s;
   logic [NCH-1:0]            sel_oh_s;
   logic [NCH-1:0]            load_s;
   logic [NCH-1:0]            drain_s;
   logic [NCH-1:0]            vld_s;
   logic [NCH-1:0][WIDTH-1:0] data_s;

   // Select decode; an out-of-range select matches no channel.
   always_comb begin
      sel_ok_s = sel_in_range(32'(sel_in), NCH);
      sel_oh_s = '0;
      for (int k = 0; k < NCH; k++) begin
         if (sel_in == SELW'(k)) begin
            sel_oh_s[k] = 1'b1;
         end else begin
            sel_oh_s[k] = 1'b0;
         end
      end
   end

   // Stall only when the selected channel is full and its sink is not taking it.
   always_comb begin
      ready_out = ~sel_ok_s | ~(|(sel_oh_s & vld_s & ~ready_in));
      acc_s     = valid_in & ready_out;
      load_s    = sel_oh_s & {NCH{acc_s}};
      drain_s   = vld_s & ready_in;
   end

   for (genvar k = 0; k < NCH; k++) begin : g_chan
      chan_reg_slice #(
         .WIDTH (WIDTH)
      ) u_slice (
         .clk_i   (clk_in),
         .rst_i   (rst_in),
         .load_i  (load_s[k]),
         .drain_i (drain_s[k]),
         .data_i  (y_in),
         .vld_o   (vld_s[k]),
         .data_o  (data_s[k])
      );
   end

   // Outputs are masked during reset so no sink handshake completes in that cycle.
   always_comb begin
      valid_out = vld_s & {NCH{~rst_in}};
      if (rst_in) begin
         data_out = '0;
      end else begin
         data_out = data_s;
      end
   end

`ifdef DEMUX_DROP_CNT_EN
   logic [DEMUX_DROP_W-1:0] drop_cnt_q;
   logic [DEMUX_DROP_W-1:0] drop_cnt_d;
   logic                    drop_s;

   // Saturating count of accepted out-of-range words.
   always_comb begin
      drop_s = acc_s & ~sel_ok_s;
      if (drop_s && (drop_cnt_q != DEMUX_DROP_MAX)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Drop counter register, cleared only by reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt_out = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_1xn_reg.sv
// Scoreboard bench for demux_1xn_reg (NCH=6 so out-of-range selects are reachable).
module tb_demux_1xn_reg;

   localparam int WIDTH = 16;
   localparam int NCH   = 6;
   localparam int SELW  = 3;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [WIDTH-1:0]          y;
   logic [SELW-1:0]           sel;
   logic                      valid;
   logic                      ready_out;
   logic [NCH-1:0][WIDTH-1:0] data_out;
   logic [NCH-1:0]            valid_out;
   logic [NCH-1:0]            ready_in;
`ifdef DEMUX_DROP_CNT_EN
   logic [15:0]               drop_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] sb_q [NCH][$];
   int               drop_m = 0;

   demux_1xn_reg #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk_in    (clk),
      .rst_in    (rst),
      .y_in      (y),
      .sel_in    (sel),
      .valid_in  (valid),
      .ready_out (ready_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in)
`ifdef DEMUX_DROP_CNT_EN
      ,
      .drop_cnt_out (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: each channel holds at most one word (its queue); a full
   // channel blocks only while its sink is not ready.
   always @(negedge clk) begin
      int  s;
      logic exp_rdy;
      logic exp_v;
      logic [WIDTH-1:0] exp_d;
      if (rst) begin
         for (int k = 0; k < NCH; k++) sb_q[k].delete();
         drop_m = 0;
      end else begin
         s = int'(sel);
         exp_rdy = 1'b1;
         if (s < NCH) begin
            if (sb_q[s].size() != 0 && !ready_in[s]) exp_rdy = 1'b0;
         end
         chk("ready_out", 64'(ready_out), 64'(exp_rdy));
         for (int k = 0; k < NCH; k++) begin
            exp_v = (sb_q[k].size() != 0);
            exp_d = exp_v ? sb_q[k][0] : 16'h0000;
            chk($sformatf("valid_out[%0d]", k), 64'(valid_out[k]), 64'(exp_v));
            chk($sformatf("data_out[%0d]", k), 64'(data_out[k]), 64'(exp_d));
         end
`ifdef DEMUX_DROP_CNT_EN
         chk("drop_cnt_out", 64'(drop_cnt), 64'(drop_m));
`endif
         for (int k = 0; k < NCH; k++) begin
            if (sb_q[k].size() != 0 && ready_in[k]) void'(sb_q[k].pop_front());
         end
         if (valid && exp_rdy) begin
            if (s < NCH) sb_q[s].push_back(y);
            else if (drop_m < 65535) drop_m = drop_m + 1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int s, input logic [WIDTH-1:0] d);
      sel   = SELW'(s);
      y     = d;
      valid = 1'b1;
   endtask

   // Present a word and hold it until accepted, with a bounded wait.
   task automatic send(input int s, input logic [WIDTH-1:0] d);
      logic ok;
      int   n;
      drive(s, d);
      n = 0;
      forever begin
         @(negedge clk);
         ok = ready_out;
         cyc();
         if (ok) break;
         n++;
         if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept sel=%0d", s);
            break;
         end
      end
      valid = 1'b0;
   endtask

   initial begin
      logic acc;
      rst = 1'b1; valid = 1'b1; sel = 3'd3; y = 16'hA5A5; ready_in = '1;
      // Reset held two cycles with valid asserted: nothing may be captured.
      cyc(); cyc();
      rst = 1'b0; valid = 1'b0;
      @(negedge clk);
      chk("reset_valid_out", 64'(valid_out), 64'd0);
      chk("reset_data_out", 64'(data_out[0]) | 64'(data_out[3]), 64'd0);
      chk("reset_ready_out", 64'(ready_out), 64'd1);
      cyc();

      // Out-of-range selects are accepted and discarded.
      send(6, 16'h0006); send(7, 16'h0007); send(6, 16'h0016);
      @(negedge clk);
      chk("oor_valid_out", 64'(valid_out), 64'd0);
`ifdef DEMUX_DROP_CNT_EN
      chk("oor_drop_cnt", 64'(drop_cnt), 64'd3);
      cyc();
      force dut.drop_cnt_q = 16'hFFFF;
      #1;
      release dut.drop_cnt_q;
      drop_m = 65535;
      send(7, 16'h0777);
      @(negedge clk);
      chk("drop_cnt_sat", 64'(drop_cnt), 64'hFFFF);
`endif
      cyc();

      // Routing.
      send(3, 16'hBEEF);
      @(negedge clk);
      chk("route_valid_out", 64'(valid_out), 64'h08);
      chk("route_data3", 64'(data_out[3]), 64'hBEEF);
      cyc();

      // Back-pressure on channel 5.
      ready_in = 6'b011111;
      send(5, 16'h1111);
      drive(5, 16'h2222);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_ready_low", 64'(ready_out), 64'd0);
         chk("bp_hold_data", 64'(data_out[5]), 64'h1111);
         cyc();
      end
      ready_in = '1;
      send(5, 16'h2222);
      cyc(); cyc();

      // Streaming one word per cycle into channel 2.
      for (int i = 0; i < 10; i++) begin
         drive(2, WIDTH'(i));
         @(negedge clk);
         chk("stream_ready", 64'(ready_out), 64'd1);
         cyc();
      end
      valid = 1'b0;
      cyc();

      // Randomised traffic with random sink readiness.
      acc = 1'b1;
      for (int i = 0; i < 400; i++) begin
         ready_in = NCH'($urandom);
         if (acc || !valid) begin
            valid = ($urandom_range(0, 3) != 0);
            sel   = SELW'($urandom_range(0, 7));
            y     = WIDTH'($urandom);
         end
         @(negedge clk);
         acc = valid & ready_out;
         cyc();
      end
      valid = 1'b0;

      // Mid-operation reset discards held words.
      ready_in = '1;
      cyc(); cyc();
      ready_in = '0;
      send(0, 16'hC0C0);
      send(1, 16'hC1C1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      ready_in = '1;
      @(negedge clk);
      chk("midrst_valid_out", 64'(valid_out), 64'd0);
      chk("midrst_data0", 64'(data_out[0]), 64'd0);
      cyc(); cyc(); cyc();

      for (int k = 0; k < NCH; k++) begin
         chk($sformatf("drained_ch%0d", k), 64'(sb_q[k].size()), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
